// File: rtl/ram_port1_arbiter_pkg.sv
// ram_port1_arbiter_pkg : shared types and constants for the RAM port-1 arbiter
// Rev 1.0
`default_nettype none

package ram_port1_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int RAM_ADDR_W = 7;
  localparam int RAM_DATA_W = 16;

endpackage

`default_nettype wire

// File: rtl/ram_port1_arbiter_rr_pick2.sv
// rr_pick2 : two-way round-robin pick; the requester not granted last wins a tie
// Rev 1.0
`default_nettype none

module rr_pick2
  import ram_port1_arbiter_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_i,
  output logic id_o,
  output logic valid_o
);

  always_comb begin
    valid_o = req_a_i | req_b_i;
    if (req_a_i && req_b_i) begin
      id_o = (last_i == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b_i) begin
      id_o = REQ_B;
    end else begin
      id_o = REQ_A;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_port1_arbiter.sv
// ram_port1_arbiter : round-robin arbiter with lock and watchdog for CPU RAM port 1
// Rev 1.0
`default_nettype none

module ram_port1_arbiter
  import ram_port1_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              a_lock_i,
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  input  logic              b_lock_i,
  output logic              b_gnt_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              ram_read_en1_o,
  output logic              ram_write_en1_o,
  output logic [ADDR_W-1:0] ram_addr1_o,
  output logic [DATA_W-1:0] ram_din1_o,
  input  logic [DATA_W-1:0] ram_dout1_i
);

  localparam logic [7:0] WDOG_LOAD = 8'(LOCK_MAX);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [7:0]        wdog_q, wdog_d;
  logic              rvalid_q, rvalid_d;
  logic              rtag_q, rtag_d;

  logic              held, own_lock;
  logic              pick_req_a, pick_req_b, pick_last;
  logic              pick_id, pick_valid;
  logic              gnt_v, sel_we, sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Watchdog value 1 marks the last cycle of a lock: that cycle arbitrates normally.
  always_comb begin
    held       = 1'b0;
    own_lock   = 1'b0;
    pick_req_a = a_req_i;
    pick_req_b = b_req_i;
    pick_last  = last_q;
    case (state_q)
      ST_OWN_A: begin
        own_lock  = a_lock_i;
        pick_last = REQ_A;
        if (wdog_q != 8'd1) begin
          held       = 1'b1;
          pick_req_b = 1'b0;
        end
      end
      ST_OWN_B: begin
        own_lock  = b_lock_i;
        pick_last = REQ_B;
        if (wdog_q != 8'd1) begin
          held       = 1'b1;
          pick_req_a = 1'b0;
        end
      end
      default: ;
    endcase
  end

  rr_pick2 u_pick (
    .req_a_i (pick_req_a),
    .req_b_i (pick_req_b),
    .last_i  (pick_last),
    .id_o    (pick_id),
    .valid_o (pick_valid)
  );

  always_comb begin
    gnt_v     = pick_valid & ~reset_i;
    sel_we    = (pick_id == REQ_B) ? b_we_i    : a_we_i;
    sel_lock  = (pick_id == REQ_B) ? b_lock_i  : a_lock_i;
    sel_addr  = (pick_id == REQ_B) ? b_addr_i  : a_addr_i;
    sel_wdata = (pick_id == REQ_B) ? b_wdata_i : a_wdata_i;

    a_gnt_o         = gnt_v & (pick_id == REQ_A);
    b_gnt_o         = gnt_v & (pick_id == REQ_B);
    ram_write_en1_o = gnt_v & sel_we;
    ram_read_en1_o  = gnt_v & ~sel_we;
    ram_addr1_o     = sel_addr;
    ram_din1_o      = sel_wdata;

    state_d  = state_q;
    wdog_d   = wdog_q;
    last_d   = last_q;
    rvalid_d = gnt_v & ~sel_we;
    rtag_d   = pick_id;

    if (held) begin
      wdog_d = wdog_q - 8'd1;
      if (!own_lock) begin
        state_d = ST_IDLE;
        wdog_d  = 8'd0;
      end
    end else begin
      state_d = ST_IDLE;
      wdog_d  = 8'd0;
      if (gnt_v && sel_lock) begin
        state_d = (pick_id == REQ_B) ? ST_OWN_B : ST_OWN_A;
        wdog_d  = WDOG_LOAD;
      end
    end
    if (gnt_v) begin
      last_d = pick_id;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      last_q   <= REQ_B;
      wdog_q   <= 8'd0;
      rvalid_q <= 1'b0;
      rtag_q   <= REQ_A;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      wdog_q   <= wdog_d;
      rvalid_q <= rvalid_d;
      rtag_q   <= rtag_d;
    end
  end

  // A read in flight when reset arrives is never delivered.
  assign a_rvalid_o = rvalid_q & ~reset_i & (rtag_q == REQ_A);
  assign b_rvalid_o = rvalid_q & ~reset_i & (rtag_q == REQ_B);
  assign a_rdata_o  = ram_dout1_i;
  assign b_rdata_o  = ram_dout1_i;

endmodule

`default_nettype wire

// File: tb/tb_ram_port1_arbiter.sv
// tb_ram_port1_arbiter : directed and random checks of ram_port1_arbiter against a behavioural model
// Rev 1.0
`default_nettype none

module tb_ram_port1_arbiter;

  localparam int LOCK_MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [6:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        ram_read_en1, ram_write_en1;
  logic [6:0]  ram_addr1;
  logic [15:0] ram_din1, ram_dout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port1_arbiter #(.ADDR_W(7), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
    .clk_i(clk), .reset_i(reset),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_lock_i(a_lock),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_lock_i(b_lock),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .ram_read_en1_o(ram_read_en1), .ram_write_en1_o(ram_write_en1),
    .ram_addr1_o(ram_addr1), .ram_din1_o(ram_din1), .ram_dout1_i(ram_dout1)
  );

  function automatic logic [15:0] init_val(input int i);
    return (i == 5) ? 16'h0042 : 16'(i * 37 + 1);
  endfunction

  // RAM: writes land at the edge, reads return only the low 7 bits one cycle later.
  logic [15:0] mem [128];
  bit          loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 128; i++) mem[i] = init_val(i);
      loaded = 1'b1;
    end else begin
      if (ram_write_en1) mem[ram_addr1] = ram_din1;
      if (ram_read_en1) ram_dout1 <= mem[ram_addr1] & 16'h007F;
    end
  end

  // Reference model: owner 0 none / 1 A / 2 B, last 1 A / 2 B, age = cycles a lock has been held.
  logic [15:0] smem [128];
  int          owner, last, age;
  logic        mrv_a, mrv_b;
  logic [15:0] mrdata;
  logic        a_sticky, b_sticky, rnd;
  logic        obs_ga, obs_gb, obs_rva, obs_rvb;
  logic [15:0] obs_ardata, obs_brdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int win, tb, nown;
    logic arb, newlock, wwe, wlock;
    logic [6:0]  waddr;
    logic [15:0] wdat;
    #4;
    win = 0; nown = owner; arb = 1'b0; newlock = 1'b0;
    if (!reset) begin
      if (owner != 0 && age < LOCK_MAX) begin
        if (owner == 1 && a_req) win = 1;
        if (owner == 2 && b_req) win = 2;
        if (!((owner == 1) ? a_lock : b_lock)) nown = 0;
      end else begin
        arb = 1'b1;
        tb = (owner != 0) ? owner : last;
        if (a_req && b_req) win = (tb == 1) ? 2 : 1;
        else if (a_req) win = 1;
        else if (b_req) win = 2;
        nown = 0;
      end
    end
    wwe   = (win == 2) ? b_we    : a_we;
    wlock = (win == 2) ? b_lock  : a_lock;
    waddr = (win == 2) ? b_addr  : a_addr;
    wdat  = (win == 2) ? b_wdata : a_wdata;
    if (arb && win != 0 && wlock) begin
      newlock = 1'b1;
      nown = win;
    end

    obs_ga = a_gnt; obs_gb = b_gnt; obs_rva = a_rvalid; obs_rvb = b_rvalid;
    obs_ardata = a_rdata; obs_brdata = b_rdata;
    chk("a_gnt", a_gnt, win == 1);
    chk("b_gnt", b_gnt, win == 2);
    chk("ram_write_en1", ram_write_en1, win != 0 && wwe);
    chk("ram_read_en1", ram_read_en1, win != 0 && !wwe);
    if (win != 0) chk("ram_addr1", ram_addr1, waddr);
    if (win != 0 && wwe) chk("ram_din1", ram_din1, wdat);
    chk("a_rvalid", a_rvalid, mrv_a && !reset);
    chk("b_rvalid", b_rvalid, mrv_b && !reset);
    if (mrv_a && !reset) chk("a_rdata", a_rdata, mrdata);
    if (mrv_b && !reset) chk("b_rdata", b_rdata, mrdata);

    @(posedge clk);
    if (reset) begin
      owner = 0; last = 2; age = 0; mrv_a = 1'b0; mrv_b = 1'b0;
    end else begin
      mrv_a = (win == 1) && !wwe;
      mrv_b = (win == 2) && !wwe;
      if (win != 0 && !wwe) mrdata = smem[waddr] & 16'h007F;
      if (win != 0 && wwe) smem[waddr] = wdat;
      if (win != 0) last = win;
      if (newlock) age = 1;
      else if (nown != 0) age = age + 1;
      else age = 0;
      owner = nown;
    end
    #1;
    if (obs_ga && !a_sticky) begin a_req = 1'b0; if (!rnd) a_lock = 1'b0; end
    if (obs_gb && !b_sticky) begin b_req = 1'b0; if (!rnd) b_lock = 1'b0; end
  endtask

  task automatic cmd_a(input logic we, input logic [6:0] addr, input logic [15:0] d, input logic lk);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d; a_lock = lk;
  endtask

  task automatic cmd_b(input logic we, input logic [6:0] addr, input logic [15:0] d, input logic lk);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d; b_lock = lk;
  endtask

  task automatic drain();
    int n = 0;
    a_sticky = 1'b0; b_sticky = 1'b0;
    while ((a_req || b_req) && n < 30) begin
      cycle();
      n++;
    end
    chk("drain_timeout", a_req | b_req, 0);
  endtask

  initial begin
    int first_b;
    for (int i = 0; i < 128; i++) smem[i] = init_val(i);
    owner = 0; last = 2; age = 0; mrv_a = 1'b0; mrv_b = 1'b0; mrdata = '0;
    a_sticky = 1'b0; b_sticky = 1'b0; rnd = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_lock = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_lock = 0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset state, including a request held during reset that must not be granted
    cycle();
    cmd_b(1'b0, 7'h03, 16'h0, 1'b0);
    cycle();
    chk("reset_b_gnt", obs_gb, 0);
    chk("reset_a_rvalid", obs_rva, 0);
    reset = 1'b0;
    drain();

    // Single read
    cmd_a(1'b0, 7'h05, 16'h0, 1'b0);
    cycle();
    chk("single_a_gnt", obs_ga, 1);
    cycle();
    chk("single_a_rvalid", obs_rva, 1);
    chk("single_a_rdata", obs_ardata, 16'h0042);
    chk("single_b_rvalid", obs_rvb, 0);

    // Contention from reset: A,B,A,B,A,B
    reset = 1'b1; cycle(); reset = 1'b0;
    a_sticky = 1'b1; b_sticky = 1'b1;
    cmd_a(1'b0, 7'h01, 16'h0, 1'b0);
    cmd_b(1'b0, 7'h02, 16'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("contend_a_gnt", obs_ga, (k % 2) == 0);
      chk("contend_b_gnt", obs_gb, (k % 2) == 1);
      if (k > 0) chk("contend_a_rvalid", obs_rva, (k % 2) == 1);
    end
    drain();

    // Locked read-modify-write by B while A keeps requesting
    cmd_b(1'b0, 7'h10, 16'h0, 1'b1);
    cycle();
    chk("rmw_b_read_gnt", obs_gb, 1);
    cmd_b(1'b1, 7'h10, 16'h0007, 1'b0);
    a_sticky = 1'b1;
    cmd_a(1'b0, 7'h20, 16'h0, 1'b0);
    cycle();
    chk("rmw_b_write_gnt", obs_gb, 1);
    chk("rmw_a_blocked", obs_ga, 0);
    cycle();
    chk("rmw_a_after", obs_ga, 1);
    drain();
    cmd_a(1'b0, 7'h10, 16'h0, 1'b0);
    cycle();
    cycle();
    chk("rmw_readback_rvalid", obs_rva, 1);
    chk("rmw_readback_rdata", obs_ardata, 16'h0007);

    // Watchdog releases A's lock after LOCK_MAX cycles
    a_sticky = 1'b1;
    cmd_a(1'b0, 7'h31, 16'h0, 1'b1);
    cycle();
    chk("wdog_first_lock_gnt", obs_ga, 1);
    b_sticky = 1'b1;
    cmd_b(1'b0, 7'h30, 16'h0, 1'b0);
    first_b = -1;
    for (int k = 1; k < 20; k++) begin
      cycle();
      if (obs_gb && first_b < 0) first_b = k;
    end
    chk("wdog_first_b_gnt", first_b, LOCK_MAX);
    a_lock = 1'b0;
    drain();

    // Only the low 7 data bits come back from the RAM
    cmd_b(1'b1, 7'h40, 16'h1FFF, 1'b0);
    cycle();
    cmd_b(1'b0, 7'h40, 16'h0, 1'b0);
    cycle();
    cycle();
    chk("mask_b_rvalid", obs_rvb, 1);
    chk("mask_b_rdata", obs_brdata, 16'h007F);

    // Reset in the cycle after a read grant drops the pending rvalid
    cmd_a(1'b0, 7'h05, 16'h0, 1'b0);
    cycle();
    chk("rstread_a_gnt", obs_ga, 1);
    reset = 1'b1;
    cycle();
    chk("rstread_no_rvalid", obs_rva, 0);
    reset = 1'b0;
    cmd_a(1'b0, 7'h06, 16'h0, 1'b0);
    cmd_b(1'b0, 7'h07, 16'h0, 1'b0);
    cycle();
    chk("rstread_tie_a", obs_ga, 1);
    chk("rstread_tie_not_b", obs_gb, 0);
    drain();

    // Random traffic with locks and occasional reset
    rnd = 1'b1;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!a_req && $urandom_range(0, 9) < 6)
        cmd_a(1'($urandom), 7'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) == 0);
      if (!b_req && $urandom_range(0, 9) < 6)
        cmd_b(1'($urandom), 7'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) == 0);
      cycle();
    end
    reset = 1'b0;
    rnd = 1'b0;
    a_lock = 1'b0;
    b_lock = 1'b0;
    drain();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_port1_arbiter.md
# ram_port1_arbiter

Shares read/write port 1 of the 16x128 CPU RAM between two requesters: A (CPU load/store unit) and B (program loader/debug). Selection is round-robin, with an optional lock for read-modify-write sequences and a watchdog that bounds how long a lock is held. The block drives the RAM port-1 strobes directly and returns read data to the requester that issued the read. RAM port 0 (instruction fetch) does not pass through this block.

## Interface
- ADDR_W, 7, RAM word address width
- DATA_W, 16, RAM data width
- LOCK_MAX, 8, maximum consecutive cycles a lock may be held before it is forcibly released (1..255)

- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- a_req / b_req  in  1  access request; held with its command until granted
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  word address
- a_wdata / b_wdata  in  DATA_W  write data
- a_lock / b_lock  in  1  keep ownership after this access
- a_gnt / b_gnt  out  1  command accepted this cycle (combinational)
- a_rvalid / b_rvalid  out  1  read data valid (registered)
- a_rdata / b_rdata  out  DATA_W  read data, qualified by rvalid
- ram_read_en1  out  1  to RAM read_en1
- ram_write_en1  out  1  to RAM write_en1
- ram_addr1  out  ADDR_W  to RAM addr1
- ram_din1  out  DATA_W  to RAM din1
- ram_dout1  in  DATA_W  from RAM dout1 (RAM delivers only bits [6:0]; upper bits arrive as 0 and pass through unchanged)

## Operation
- States: IDLE, OWN_A, OWN_B. Round-robin pointer `last` records the most recently granted requester.
- IDLE: one requester asserts req -> it is granted. Both assert req -> the one not equal to `last` is granted. Neither -> no grant, RAM strobes 0.
- Every grant: `last` <= granted requester.
- Grant with lock=1 -> go to OWN_x and load the watchdog with LOCK_MAX.
- OWN_x: only x may be granted; the other requester's req is ignored and its gnt stays 0. Watchdog decrements every cycle.
- OWN_x exits to IDLE when x presents lock=0. If x also asserts req in that cycle, that access is granted as the final locked access.
- OWN_x also exits to IDLE when the watchdog reaches 0. That cycle behaves as IDLE arbitration with x as `last`, so the other requester wins a tie.
- At most one gnt is high per cycle. ram_read_en1 and ram_write_en1 are never both 1.
- Granted write: ram_write_en1=1, ram_read_en1=0, with the requester's addr and wdata.
- Granted read: ram_read_en1=1, ram_write_en1=0.
- Read return tag: a 1-entry register captures the reader's id and issues rvalid to that requester only. rdata for both requesters is ram_dout1.
- Writes produce no rvalid.

## Timing
- gnt and the RAM strobes are combinational in the request cycle; the RAM samples them at the next edge.
- Read latency: rvalid is asserted exactly 1 cycle after gnt, with ram_dout1 valid in the same cycle.
- Back-to-back grants are allowed every cycle, alternating A/B under continuous contention. Throughput is 1 access/cycle.
- A requester may drop req only after gnt. Any change to req or command before gnt is a protocol violation with undefined result.
- Reset values: state IDLE, `last`=B (so A wins the first tie), watchdog 0, a_rvalid=b_rvalid=0, a_gnt=b_gnt=0, ram strobes 0.
- While reset=1: gnt and strobes are forced to 0.
- Reset asserted with a read in flight: the pending rvalid is dropped, not delivered.
- Locked write followed by an unlocked read to the same address: the read returns the newly written value, because the RAM write completes at the grant edge.

## Structure
- Shared package: state encoding (IDLE/OWN_A/OWN_B), requester id constants (REQ_A=0, REQ_B=1), and default widths ADDR_W/DATA_W matching the RAM.
- One natural sub-module, `rr_pick2`: combinational 2-way round-robin pick from (req_a, req_b, last) -> grant id and valid.
- The FSM, watchdog counter, and rvalid tag register stay in the top level.

## Test plan
- Single read: A reads addr 0x05 holding 0x0042 -> a_gnt in the same cycle, a_rvalid 1 cycle later with a_rdata=0x0042; b_rvalid stays 0.
- Contention: A and B both hold read requests for 6 cycles from reset -> grants go A,B,A,B,A,B, and each rvalid follows its own grant by 1 cycle.
- Lock RMW: B reads 0x10 with lock=1, then writes 0x10=0x0007 with lock=0, while A requests continuously -> A gets no gnt until the cycle after B's write; a subsequent A read of 0x10 returns 0x0007.
- Watchdog: A holds lock=1 and req for 20 cycles with LOCK_MAX=8 and B requesting -> b_gnt occurs 8 cycles after A's first locked grant.
- Data mask: B writes 0x1FFF, then reads it -> b_rdata=0x007F.
- Reset mid-read: assert reset in the cycle after a read gnt -> no rvalid appears; after reset, the first tie goes to A.
